// File: rtl/rtcl_p3s7_hs_frame_ctl.sv
// Frame gate / geometry shadow / size and stall checker in front of the PYTHON300 HS converter.
// Params latch only when a frame is accepted; a stalled frame is closed with a synthetic last beat.
module rtcl_p3s7_hs_frame_ctl #(
  parameter int X_BITS       = 10,
  parameter int Y_BITS       = 10,
  parameter int RAW_BITS     = 10,
  parameter int TIMEOUT_BITS = 24,
  parameter int FCNT_BITS    = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    ctl_enable,
  input  logic                    ctl_oneshot,
  input  logic                    ctl_update,
  input  logic                    ctl_err_clear,
  input  logic [X_BITS-1:0]       cfg_black_width,
  input  logic [Y_BITS-1:0]       cfg_black_height,
  input  logic [X_BITS-1:0]       cfg_image_width,
  input  logic [Y_BITS-1:0]       cfg_image_height,
  input  logic [TIMEOUT_BITS-1:0] cfg_timeout,
  input  logic                    s_first,
  input  logic                    s_last,
  input  logic [RAW_BITS-1:0]     s_data,
  input  logic                    s_valid,
  output logic                    m_first,
  output logic                    m_last,
  output logic [RAW_BITS-1:0]     m_data,
  output logic                    m_valid,
  output logic [X_BITS-1:0]       param_black_width,
  output logic [Y_BITS-1:0]       param_black_height,
  output logic [X_BITS-1:0]       param_image_width,
  output logic [Y_BITS-1:0]       param_image_height,
  output logic                    stat_busy,
  output logic [FCNT_BITS-1:0]    stat_frame_count,
  output logic                    stat_update_ack,
  output logic                    stat_err_size,
  output logic                    stat_err_timeout
);

  localparam int CNT_BITS = X_BITS + Y_BITS + 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t                  state, state_nxt;
  logic                    oneshot_pend, update_pend;
  logic [CNT_BITS-1:0]     cnt, cnt_base, cnt_nxt, exp_cnt;
  logic [TIMEOUT_BITS-1:0] idle_cnt, idle_inc, idle_nxt;
  logic                    fwd, apply, frame_done, restart, stall;
  logic [X_BITS-1:0]       eff_bw, eff_iw;
  logic [Y_BITS-1:0]       eff_bh, eff_ih;
  logic [X_BITS+Y_BITS-1:0] prod_b, prod_i;

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    apply     = 1'b0;
    restart   = 1'b0;
    stall     = 1'b0;
    cnt_base  = cnt;
    idle_inc  = idle_cnt + 1'b1;
    idle_nxt  = idle_cnt;
    case (state)
      IDLE: if (ctl_enable || oneshot_pend) state_nxt = ARMED;
      ARMED:
        // Only a frame start is accepted here, so capture never begins mid-frame.
        if (s_valid && s_first) begin
          fwd       = 1'b1;
          apply     = update_pend;
          cnt_base  = '0;
          idle_nxt  = '0;
          state_nxt = CAPTURE;
        end
      CAPTURE:
        if (s_valid) begin
          fwd      = 1'b1;
          idle_nxt = '0;
          if (s_first) begin
            restart  = 1'b1;
            cnt_base = '0;
          end
        end else begin
          idle_nxt = idle_inc;
          stall    = (cfg_timeout != '0) && (idle_inc == cfg_timeout);
        end
      default: state_nxt = IDLE;
    endcase
    frame_done = fwd && s_last;
    if (frame_done || stall) state_nxt = ctl_enable ? ARMED : IDLE;
    cnt_nxt = cnt_base + {{(CNT_BITS-1){1'b0}}, (s_data != '0) && !s_last};
    // A single-beat frame checks against the params being applied in that same cycle.
    eff_bw  = apply ? cfg_black_width  : param_black_width;
    eff_bh  = apply ? cfg_black_height : param_black_height;
    eff_iw  = apply ? cfg_image_width  : param_image_width;
    eff_ih  = apply ? cfg_image_height : param_image_height;
    prod_b  = {{Y_BITS{1'b0}}, eff_bw} * {{X_BITS{1'b0}}, eff_bh};
    prod_i  = {{Y_BITS{1'b0}}, eff_iw} * {{X_BITS{1'b0}}, eff_ih};
    exp_cnt = {1'b0, prod_b} + {1'b0, prod_i};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state              <= IDLE;
      oneshot_pend       <= 1'b0;
      update_pend        <= 1'b1;
      cnt                <= '0;
      idle_cnt           <= '0;
      m_first            <= 1'b0;
      m_last             <= 1'b0;
      m_data             <= '0;
      m_valid            <= 1'b0;
      param_black_width  <= '0;
      param_black_height <= '0;
      param_image_width  <= '0;
      param_image_height <= '0;
      stat_frame_count   <= '0;
      stat_update_ack    <= 1'b0;
      stat_err_size      <= 1'b0;
      stat_err_timeout   <= 1'b0;
    end else begin
      state           <= state_nxt;
      idle_cnt        <= idle_nxt;
      stat_update_ack <= apply;
      m_valid         <= fwd || stall;
      m_first         <= fwd && s_first;
      m_last          <= frame_done || stall;
      m_data          <= fwd ? s_data : '0;
      if (fwd) cnt <= cnt_nxt;
      if (apply) begin
        param_black_width  <= cfg_black_width;
        param_black_height <= cfg_black_height;
        param_image_width  <= cfg_image_width;
        param_image_height <= cfg_image_height;
      end
      // Requests arriving in the consuming cycle survive for the next frame.
      update_pend  <= (update_pend && !apply) || ctl_update;
      oneshot_pend <= (oneshot_pend && !(frame_done || stall)) || ctl_oneshot;
      if (frame_done) stat_frame_count <= stat_frame_count + 1'b1;
      stat_err_size    <= (stat_err_size && !ctl_err_clear) || restart ||
                          (frame_done && (cnt_base != exp_cnt));
      stat_err_timeout <= (stat_err_timeout && !ctl_err_clear) || stall;
    end
  end

  assign stat_busy = (state != IDLE);

endmodule

// File: tb/tb_rtcl_p3s7_hs_frame_ctl.sv
// Directed plus randomized bench for rtcl_p3s7_hs_frame_ctl against a frame-level reference model.
module tb_rtcl_p3s7_hs_frame_ctl;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        ctl_enable = 0, ctl_oneshot = 0, ctl_update = 0, ctl_err_clear = 0;
  logic [9:0]  cfg_black_width = 0, cfg_black_height = 0, cfg_image_width = 0, cfg_image_height = 0;
  logic [23:0] cfg_timeout = 0;
  logic        s_first = 0, s_last = 0, s_valid = 0;
  logic [9:0]  s_data = 0;
  logic        m_first, m_last, m_valid;
  logic [9:0]  m_data;
  logic [9:0]  param_black_width, param_black_height, param_image_width, param_image_height;
  logic        stat_busy, stat_update_ack, stat_err_size, stat_err_timeout;
  logic [31:0] stat_frame_count;

  rtcl_p3s7_hs_frame_ctl dut (
    .aclk(aclk), .areset(areset), .ctl_enable(ctl_enable), .ctl_oneshot(ctl_oneshot),
    .ctl_update(ctl_update), .ctl_err_clear(ctl_err_clear),
    .cfg_black_width(cfg_black_width), .cfg_black_height(cfg_black_height),
    .cfg_image_width(cfg_image_width), .cfg_image_height(cfg_image_height),
    .cfg_timeout(cfg_timeout), .s_first(s_first), .s_last(s_last), .s_data(s_data),
    .s_valid(s_valid), .m_first(m_first), .m_last(m_last), .m_data(m_data), .m_valid(m_valid),
    .param_black_width(param_black_width), .param_black_height(param_black_height),
    .param_image_width(param_image_width), .param_image_height(param_image_height),
    .stat_busy(stat_busy), .stat_frame_count(stat_frame_count), .stat_update_ack(stat_update_ack),
    .stat_err_size(stat_err_size), .stat_err_timeout(stat_err_timeout)
  );

  always #5 aclk = ~aclk;

  int tb_cyc = 0;
  always @(posedge aclk) tb_cyc <= tb_cyc + 1;

  typedef struct {
    int        cyc;
    logic [9:0] data;
    bit        first;
    bit        last;
  } beat_t;
  beat_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: frame-level view of what the controller should be doing.
  bit armed, in_frame, os_pend, upd_pend, e_size, e_to;
  int pbw, pbh, piw, pih, fc, cnt_m, idle_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge aclk) begin
    if (m_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
      else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_cycle", 64'(tb_cyc), 64'(b.cyc));
        chk("beat_data", 64'(m_data), 64'(b.data));
        chk("beat_first", 64'(m_first), 64'(b.first));
        chk("beat_last", 64'(m_last), 64'(b.last));
      end
    end
  end

  function automatic int words_active();
    return pbw * pbh + piw * pih;
  endfunction

  function automatic int words_next();
    if (upd_pend)
      return int'(cfg_black_width) * int'(cfg_black_height) + int'(cfg_image_width) * int'(cfg_image_height);
    return words_active();
  endfunction

  task automatic model_reset();
    armed = 0; in_frame = 0; os_pend = 0; upd_pend = 1; e_size = 0; e_to = 0;
    pbw = 0; pbh = 0; piw = 0; pih = 0; fc = 0; cnt_m = 0; idle_m = 0;
    exp_q.delete();
  endtask

  task automatic end_frame();
    in_frame = 0;
    armed    = ctl_enable;
    os_pend  = 0;
  endtask

  task automatic push_beat(input logic [9:0] d, input bit f, input bit l);
    beat_t b;
    b.cyc = tb_cyc + 1; b.data = d; b.first = f; b.last = l;
    exp_q.push_back(b);
  endtask

  // One clock of stimulus; the model predicts the effect of this cycle's inputs.
  task automatic cyc_step(input bit v, input bit f, input bit l, input logic [9:0] d);
    bit idle0, acc, ack;
    s_valid = v; s_first = f; s_last = l; s_data = d;
    idle0 = !armed && !in_frame;
    acc = 0; ack = 0;
    if (ctl_err_clear) begin e_size = 0; e_to = 0; end
    if (v) begin
      if (!in_frame && armed && f) begin
        acc = 1; in_frame = 1; armed = 0; cnt_m = 0; idle_m = 0;
        if (upd_pend) begin
          pbw = cfg_black_width; pbh = cfg_black_height;
          piw = cfg_image_width; pih = cfg_image_height;
          upd_pend = 0; ack = 1;
        end
      end
      if (in_frame) begin
        push_beat(d, f, l);
        idle_m = 0;
        if (f && !acc) begin e_size = 1; cnt_m = 0; end
        if (l) begin
          if (cnt_m != words_active()) e_size = 1;
          fc++;
          end_frame();
        end else if (d != 0) cnt_m++;
      end
    end else if (in_frame) begin
      idle_m++;
      if (cfg_timeout != 0 && idle_m == int'(cfg_timeout)) begin
        e_to = 1;
        push_beat(10'd0, 1'b0, 1'b1);
        end_frame();
      end
    end
    if (idle0 && (ctl_enable || os_pend)) armed = 1;
    if (ctl_update) upd_pend = 1;
    if (ctl_oneshot) os_pend = 1;
    @(posedge aclk); #1;
    ctl_oneshot = 0; ctl_update = 0; ctl_err_clear = 0;
    s_valid = 0; s_first = 0; s_last = 0; s_data = 0;
    chk("update_ack", 64'(stat_update_ack), 64'(ack));
    chk("busy", 64'(stat_busy), 64'(armed || in_frame));
    chk("frame_count", 64'(stat_frame_count), 64'(fc));
    chk("err_size", 64'(stat_err_size), 64'(e_size));
    chk("err_timeout", 64'(stat_err_timeout), 64'(e_to));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_step(0, 0, 0, 10'd0);
  endtask

  task automatic words(input int n, input bit start);
    for (int i = 0; i < n; i++) cyc_step(1, start && i == 0, 0, 10'($urandom_range(1, 1023)));
  endtask

  task automatic last_beat();
    cyc_step(1, 0, 1, 10'($urandom_range(0, 1023)));
  endtask

  task automatic send_frame(input int nz, input int nzero, input bit do_last);
    int tot, zl, nl;
    logic [9:0] d;
    tot = nz + nzero; zl = nzero; nl = nz;
    for (int i = 0; i < tot; i++) begin
      if (zl > 0 && (nl == 0 || $urandom_range(0, 3) == 0)) begin d = 10'd0; zl--; end
      else begin d = 10'($urandom_range(1, 1023)); nl--; end
      cyc_step(1, i == 0, 0, d);
    end
    if (do_last) cyc_step(1, tot == 0, 1, 10'($urandom_range(0, 1023)));
  endtask

  task automatic chk_params();
    chk("param_black_width", 64'(param_black_width), 64'(pbw));
    chk("param_black_height", 64'(param_black_height), 64'(pbh));
    chk("param_image_width", 64'(param_image_width), 64'(piw));
    chk("param_image_height", 64'(param_image_height), 64'(pih));
  endtask

  task automatic do_reset();
    areset = 1;
    s_valid = 0; s_first = 0; s_last = 0; s_data = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 0;
    model_reset();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_first", 64'(m_first), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_busy", 64'(stat_busy), 64'd0);
    chk("rst_frame_count", 64'(stat_frame_count), 64'd0);
    chk("rst_update_ack", 64'(stat_update_ack), 64'd0);
    chk("rst_err_size", 64'(stat_err_size), 64'd0);
    chk("rst_err_timeout", 64'(stat_err_timeout), 64'd0);
    chk_params();
  endtask

  task automatic set_cfg(input int bw, input int bh, input int iw, input int ih);
    cfg_black_width = 10'(bw); cfg_black_height = 10'(bh);
    cfg_image_width = 10'(iw); cfg_image_height = 10'(ih);
  endtask

  initial begin
    int e, nz;
    do_reset();

    // 4x2 black + 8x4 image = 40 counted words
    set_cfg(4, 2, 8, 4);
    ctl_enable = 1;
    idle(3);
    send_frame(40, 0, 1);
    idle(3);
    chk("t1_frame_count", 64'(stat_frame_count), 64'd1);
    chk_params();

    // one-shot capture with enable low: only the first of three frames goes through
    ctl_enable = 0;
    ctl_oneshot = 1;
    idle(3);
    for (int k = 0; k < 3; k++) begin
      send_frame(40, 2, 1);
      idle(2);
      if (k == 0) chk("t2_busy_after_last", 64'(stat_busy), 64'd0);
    end
    chk("t2_frame_count", 64'(stat_frame_count), 64'd2);

    // update request mid-frame takes effect at the next frame start only
    ctl_enable = 1;
    idle(3);
    words(10, 1);
    set_cfg(2, 1, 4, 2);
    ctl_update = 1;
    words(30, 0);
    last_beat();
    idle(3);
    chk("t3_black_width_held", 64'(param_black_width), 64'd4);
    chk("t3_err_size_clean", 64'(stat_err_size), 64'd0);
    words(10, 1);
    last_beat();
    idle(2);
    chk("t3_image_width_new", 64'(param_image_width), 64'd4);
    chk_params();

    // short frame sets sticky size error; clear removes it
    words(9, 1);
    last_beat();
    idle(5);
    chk("t4_err_size_sticky", 64'(stat_err_size), 64'd1);
    ctl_err_clear = 1;
    idle(2);
    chk("t4_err_size_cleared", 64'(stat_err_size), 64'd0);

    // stall inside a frame: timeout fires and a synthetic last beat is injected
    cfg_timeout = 24'd16;
    words(5, 1);
    idle(20);
    chk("t5_err_timeout", 64'(stat_err_timeout), 64'd1);
    chk("t5_frames_unchanged", 64'(stat_frame_count), 64'(fc));
    ctl_err_clear = 1;
    idle(2);

    // enable dropped mid-frame: frame still completes, then controller idles
    words(3, 1);
    ctl_enable = 0;
    words(7, 0);
    last_beat();
    idle(2);
    chk("t7_busy_low", 64'(stat_busy), 64'd0);

    // mid-frame stream start is dropped; reset mid-capture returns to reset values
    ctl_enable = 1;
    idle(2);
    words(4, 0);
    words(6, 1);
    do_reset();
    set_cfg(1, 1, 2, 2);
    idle(2);
    send_frame(5, 1, 1);
    idle(2);
    chk_params();

    // randomized frames, including zero-height geometry (single-beat frames),
    // off-by-one lengths, missing last markers and update/oneshot pulses
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        ctl_update = 1;
      end
      ctl_enable = ($urandom_range(0, 4) != 0);
      if (!ctl_enable && $urandom_range(0, 1) == 1) ctl_oneshot = 1;
      if ($urandom_range(0, 5) == 0) ctl_err_clear = 1;
      idle($urandom_range(2, 5));
      e  = words_next();
      nz = e + $urandom_range(0, 2) - 1;
      if (nz < 0 || $urandom_range(0, 5) == 0) nz = e;
      send_frame(nz, $urandom_range(0, 3), $urandom_range(0, 9) != 0);
      chk_params();
    end
    ctl_enable = 0;
    idle(20);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
